// File: rtl/modmul_arbiter.sv
// Round-robin front end for a shared pipelined 256-bit modular multiplier:
// credit-limited issue, in-order tag tracking and a first-word-fall-through result FIFO.
module modmul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [256*NUM_REQ-1:0]   req_x,
  input  logic [256*NUM_REQ-1:0]   req_y,
  output logic                     mul_in_valid,
  output logic [255:0]             mul_x,
  output logic [255:0]             mul_y,
  input  logic                     mul_out_valid,
  input  logic [255:0]             mul_q,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [1:0]               rsp_id,
  output logic [255:0]             rsp_q,
  output logic                     busy,
  output logic                     err_orphan
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 + 256;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // req_valid/rsp_valid may not depend on ready, req_ready/rsp_ready may depend on valid.

  // Credits reserve a result FIFO slot at issue time, so results can never overflow it.
  logic [CW-1:0]       reserved;
  logic [1:0]          last_grant;
  logic                can_issue;
  logic                accept;
  logic                found;
  logic [1:0]          cand;
  logic [1:0]          grant_idx;
  logic [NUM_REQ-1:0]  grant;

  logic [1:0]          tag_mem [FIFO_DEPTH];
  logic [AW-1:0]       tag_wr;
  logic [AW-1:0]       tag_rd;
  logic [CW-1:0]       tag_count;
  logic                tag_pop;

  logic [EW-1:0]       res_mem [FIFO_DEPTH];
  logic [AW-1:0]       res_wr;
  logic [AW-1:0]       res_rd;
  logic [CW-1:0]       res_count;
  logic                res_pop;

  assign can_issue = !reset && (reserved < CW'(FIFO_DEPTH));

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

  assign req_ready = can_issue ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  assign tag_pop   = mul_out_valid && (tag_count != '0);
  assign rsp_valid = (res_count != '0);
  assign res_pop   = rsp_valid && rsp_ready;
  assign busy      = (reserved != '0);
  assign rsp_id    = res_mem[res_rd][EW-1:256];
  assign rsp_q     = res_mem[res_rd][255:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      reserved     <= '0;
      last_grant   <= 2'd3;
      mul_in_valid <= 1'b0;
      tag_wr       <= '0;
      tag_rd       <= '0;
      tag_count    <= '0;
      res_wr       <= '0;
      res_rd       <= '0;
      res_count    <= '0;
      err_orphan   <= 1'b0;
    end else begin
      mul_in_valid <= accept;
      if (accept) last_grant <= grant_idx;

      case ({accept, res_pop})
        2'b10:   reserved <= reserved + CW'(1);
        2'b01:   reserved <= reserved - CW'(1);
        default: reserved <= reserved;
      endcase

      if (accept)  tag_wr <= tag_wr + AW'(1);
      if (tag_pop) tag_rd <= tag_rd + AW'(1);
      case ({accept, tag_pop})
        2'b10:   tag_count <= tag_count + CW'(1);
        2'b01:   tag_count <= tag_count - CW'(1);
        default: tag_count <= tag_count;
      endcase

      if (tag_pop) res_wr <= res_wr + AW'(1);
      if (res_pop) res_rd <= res_rd + AW'(1);
      case ({tag_pop, res_pop})
        2'b10:   res_count <= res_count + CW'(1);
        2'b01:   res_count <= res_count - CW'(1);
        default: res_count <= res_count;
      endcase

      // A result with no outstanding tag cannot be attributed; drop it and flag.
      if (mul_out_valid && (tag_count == '0)) err_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      mul_x           <= req_x[256*grant_idx +: 256];
      mul_y           <= req_y[256*grant_idx +: 256];
      tag_mem[tag_wr] <= grant_idx;
    end
    if (tag_pop) res_mem[res_wr] <= {tag_mem[tag_rd], mul_q};
  end

endmodule

// File: tb/tb_modmul_arbiter.sv
// Bench for modmul_arbiter: stub 29-cycle multiplier, arbitration/credit reference model,
// expected-result queue checked by an independent monitor, plus directed scenarios.
module tb_modmul_arbiter;
  localparam int DEPTH = 32;
  localparam int LAT   = 29;
  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

  logic           clock;
  logic           reset;
  logic [3:0]     req_valid;
  logic [3:0]     req_ready;
  logic [1023:0]  req_x;
  logic [1023:0]  req_y;
  logic           mul_in_valid;
  logic [255:0]   mul_x;
  logic [255:0]   mul_y;
  logic           mul_out_valid;
  logic [255:0]   mul_q;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [255:0]   rsp_q;
  logic           busy;
  logic           err_orphan;

  modmul_arbiter #(.NUM_REQ(4), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .mul_in_valid(mul_in_valid), .mul_x(mul_x), .mul_y(mul_y),
    .mul_out_valid(mul_out_valid), .mul_q(mul_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q),
    .busy(busy), .err_orphan(err_orphan)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic inject = 1'b0;

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [255:0] modmul(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] prod;
    prod = {256'b0, x} * {256'b0, y};
    return 256'(prod % {256'b0, P});
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [259:0] act, input logic [259:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // stub multiplier: fixed latency, in-order results
  typedef struct { int due; logic [255:0] q; } pend_t;
  pend_t pend_q[$];
  initial begin
    pend_t e;
    mul_out_valid = 1'b0;
    mul_q = '0;
    forever begin
      @(posedge clock);
      #1;
      mul_out_valid = 1'b0;
      if (reset) begin
        pend_q.delete();
      end else begin
        if (inject) begin
          mul_out_valid = 1'b1;
          mul_q = rand256();
        end else if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
          e = pend_q.pop_front();
          mul_out_valid = 1'b1;
          mul_q = e.q;
        end
        if (mul_in_valid) pend_q.push_back('{cyc + LAT, modmul(mul_x, mul_y)});
      end
    end
  end

  // reference model state and scoreboard
  logic [257:0] exp_q[$];
  int           m_reserved = 0;
  int           m_last = 3;
  int           m_inflight = 0;
  logic         m_err = 1'b0;
  logic         m_mi = 1'b0;
  logic [255:0] m_mx = '0;
  logic [255:0] m_my = '0;
  logic         prev_hold = 1'b0;
  logic [257:0] prev_rsp = '0;
  int           dut_acc = 0;
  int           last_mov_cyc = 0;

  initial begin
    int g;
    logic [3:0] rdy_exp;
    logic pop;
    logic [255:0] ox, oy;
    logic [257:0] head;
    forever begin
      @(negedge clock);
      g = -1;
      rdy_exp = '0;
      if (!reset && m_reserved < DEPTH) begin
        for (int k = 1; k <= 4; k++) begin
          int i;
          i = (m_last + k) % 4;
          if (g < 0 && req_valid[i]) g = i;
        end
        if (g >= 0) rdy_exp[g] = 1'b1;
      end
      check("req_ready", 260'(req_ready), 260'(rdy_exp));
      check("busy", 260'(busy), 260'(m_reserved != 0));
      check("err_orphan", 260'(err_orphan), 260'(m_err));
      check("mul_in_valid", 260'(mul_in_valid), 260'(m_mi));
      if (m_mi) begin
        check("mul_x", 260'(mul_x), 260'(m_mx));
        check("mul_y", 260'(mul_y), 260'(m_my));
      end
      if (!reset && prev_hold) begin
        check("rsp_hold_valid", 260'(rsp_valid), 260'(1'b1));
        check("rsp_hold_data", 260'({rsp_id, rsp_q}), 260'(prev_rsp));
      end
      pop = !reset && rsp_valid && rsp_ready;
      if (pop) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexpected: got id=%0d q=%h expected nothing", rsp_id, rsp_q);
        end else begin
          head = exp_q.pop_front();
          check("rsp", 260'({rsp_id, rsp_q}), 260'(head));
        end
      end
      if (mul_out_valid) last_mov_cyc = cyc;
      if (reset) begin
        m_reserved = 0;
        m_last = 3;
        m_inflight = 0;
        m_err = 1'b0;
        m_mi = 1'b0;
        prev_hold = 1'b0;
        exp_q.delete();
      end else begin
        if (|(req_valid & req_ready)) dut_acc++;
        if (mul_out_valid) begin
          if (m_inflight == 0) m_err = 1'b1;
          else m_inflight--;
        end
        m_mi = (g >= 0);
        if (g >= 0) begin
          ox = req_x[256*g +: 256];
          oy = req_y[256*g +: 256];
          exp_q.push_back({2'(g), modmul(ox, oy)});
          m_last = g;
          m_inflight++;
          m_mx = ox;
          m_my = oy;
        end
        m_reserved = m_reserved + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
        prev_hold = rsp_valid && !rsp_ready;
        prev_rsp = {rsp_id, rsp_q};
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      req_x[256*i +: 256] = rand256();
      req_y[256*i +: 256] = rand256();
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("reset_busy", 260'(busy), 260'(1'b0));
    check("reset_rsp_valid", 260'(rsp_valid), 260'(1'b0));
    check("reset_req_ready", 260'(req_ready), 260'(4'b0));
    reset = 1'b0;

    // all requesters streaming with a free consumer: strict rotation
    rsp_ready = 1'b1;
    req_valid = 4'hf;
    for (int i = 0; i < 200; i++) begin
      rand_ops();
      tick();
    end
    req_valid = '0;
    repeat (60) tick();
    check("rotation_drained", 260'(exp_q.size()), 260'(0));

    // credit limit with a stalled consumer
    do_reset();
    rsp_ready = 1'b0;
    rand_ops();
    dut_acc = 0;
    req_valid = 4'b0100;
    repeat (60) tick();
    check("credit_accepts", 260'(dut_acc), 260'(32));
    check("credit_ready_low", 260'(req_ready), 260'(4'b0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    repeat (5) tick();
    check("credit_one_more", 260'(dut_acc), 260'(33));
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (80) tick();
    check("credit_drained", 260'(exp_q.size()), 260'(0));

    // single small request from requester 1
    do_reset();
    rsp_ready = 1'b0;
    req_x = '0;
    req_y = '0;
    req_x[256 +: 256] = 256'd2;
    req_y[256 +: 256] = 256'd3;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    for (int i = 0; i < 60 && !rsp_valid; i++) tick();
    check("single_rsp_valid", 260'(rsp_valid), 260'(1'b1));
    check("single_latency", 260'(cyc - last_mov_cyc), 260'(1));
    check("single_rsp_id", 260'(rsp_id), 260'(2'd1));
    check("single_rsp_q", 260'(rsp_q), 260'(6));
    check("single_busy", 260'(busy), 260'(1'b1));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    check("single_busy_after", 260'(busy), 260'(1'b0));

    // orphan result
    do_reset();
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick();
    tick();
    check("orphan_flag", 260'(err_orphan), 260'(1'b1));
    check("orphan_no_rsp", 260'(rsp_valid), 260'(1'b0));
    repeat (20) tick();
    check("orphan_sticky", 260'(err_orphan), 260'(1'b1));

    // reset with ten operations in flight
    do_reset();
    rsp_ready = 1'b0;
    rand_ops();
    req_valid = 4'hf;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("midreset_busy", 260'(busy), 260'(1'b0));
    check("midreset_rsp_valid", 260'(rsp_valid), 260'(1'b0));
    check("midreset_req_ready", 260'(req_ready), 260'(4'b0));
    reset = 1'b0;
    #1;
    check("midreset_first_grant", 260'(req_ready), 260'(4'b0001));
    check("midreset_orphan_clear", 260'(err_orphan), 260'(1'b0));

    // randomized traffic with alternating consumer pressure
    for (int i = 0; i < 1500; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      if ((i / 300) % 2 == 0) rsp_ready = ($urandom_range(0, 3) != 0);
      else rsp_ready = ($urandom_range(0, 3) == 0);
      rand_ops();
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (100) tick();
    check("final_drained", 260'(exp_q.size()), 260'(0));
    check("final_busy", 260'(busy), 260'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modmul_arbiter.md
MODMUL_ARBITER -- requirements
Module: modmul_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requesters (fixed at 4 for this revision).
REQ-002 Parameter: FIFO_DEPTH, default 32, result FIFO and tag FIFO depth (power of two).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  4  per-requester operation request.
REQ-006 req_ready  output  4  per-requester accept; the request is taken when req_valid[i] and req_ready[i] are both high.
REQ-007 req_x, req_y  input  4x256 each  operands; requester i occupies bits [256*i+255:256*i].
REQ-008 mul_in_valid  output  1  issue strobe to the pipelined 256-bit modular multiplier.
REQ-009 mul_x, mul_y  output  256 each  operands to the multiplier.
REQ-010 mul_out_valid  input  1  multiplier result strobe; results return in issue order.
REQ-011 mul_q  input  256  multiplier result.
REQ-012 rsp_valid  output  1  result available at the FIFO head.
REQ-013 rsp_ready  input  1  consumer accept.
REQ-014 rsp_id  output  2  requester index for rsp_q.
REQ-015 rsp_q  output  256  reduced product.
REQ-016 busy  output  1  high while any operation is in flight or buffered.
REQ-017 err_orphan  output  1  sticky: a result arrived with no outstanding tag.

Function
REQ-018 Credit counter reserved (0..FIFO_DEPTH): +1 on issue, -1 on pop (rsp_valid && rsp_ready); simultaneous issue and pop leaves it unchanged.
REQ-019 Issue is permitted only when the registered reserved < FIFO_DEPTH; a pop in the same cycle does not enable issue in that cycle.
REQ-020 Round-robin arbitration: search starts at last_grant+1 mod 4 and grants the first i with req_valid[i]; at most one req_ready bit is high per cycle.
REQ-021 req_ready is combinational from req_valid, last_grant and the credit check; all bits are 0 when issue is not permitted.
REQ-022 last_grant updates to the granted index only on an accepted request; otherwise it holds.
REQ-023 On accept, mul_in_valid is 1 in the next cycle with mul_x/mul_y equal to the granted operands; otherwise mul_in_valid is 0. Maximum issue rate is one per cycle.
REQ-024 On accept, the granted index is pushed into an in-order tag FIFO.
REQ-025 On mul_out_valid with a non-empty tag FIFO: pop the tag and push {tag, mul_q} into the result FIFO in the same cycle.
REQ-026 On mul_out_valid with an empty tag FIFO: discard the result and set err_orphan; only reset clears err_orphan.
REQ-027 The result FIFO is first-word-fall-through: rsp_valid = not empty, and rsp_id/rsp_q show the head entry.
REQ-028 A result pushed into an empty result FIFO shows rsp_valid=1 in the next cycle.
REQ-029 rsp_id/rsp_q hold stable while rsp_valid=1 and rsp_ready=0.
REQ-030 Push and pop in the same cycle on a full or empty FIFO are both legal; occupancy stays within bounds by REQ-019, and overflow is impossible.
REQ-031 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-032 busy = (reserved != 0).

Reset
REQ-033 Reset clears: reserved=0; both FIFOs empty; last_grant=3 (requester 0 has first priority); mul_in_valid=0; rsp_valid=0; err_orphan=0; busy=0; req_ready=0 during reset.
REQ-034 Reset mid-operation abandons all in-flight and buffered results; datapath registers need no reset.

Verification
REQ-035 All four req_valid held high, rsp_ready=1, stub multiplier with latency 29 -> grants in order 0,1,2,3,0,...; one mul_in_valid per cycle; rsp_id returns 0,1,2,3,... with each rsp_q = x*y mod p.
REQ-036 rsp_ready=0, requester 2 streaming -> exactly 32 accepts, then req_ready=0; after one pop, exactly one further accept, starting the cycle after the pop.
REQ-037 Single request x=2, y=3 from requester 1 when idle -> mul_in_valid one cycle after accept; rsp_valid one cycle after mul_out_valid with rsp_id=1, rsp_q=6; busy falls after the pop.
REQ-038 mul_out_valid pulsed with no prior issue -> err_orphan=1, rsp_valid stays 0; err_orphan holds until reset.
REQ-039 Reset asserted with 10 operations in flight -> next cycle: busy=0, rsp_valid=0, req_ready=0; after reset deasserts, the first grant goes to requester 0.
